// File: rtl/n1_mem_pkg.sv
// Shared defaults and types for the n1 single-port RAM arbiter.
package n1_mem_pkg;

  localparam int N1_ADDR_W = 8;
  localparam int N1_DATA_W = 16;

  // Bit positions inside the one-hot grant vector produced by n1_arb_pick.
  localparam int GNT_LDR = 0;
  localparam int GNT_DAT = 1;
  localparam int GNT_FET = 2;

  typedef enum logic [1:0] {OWN_NONE, OWN_LDR, OWN_DAT, OWN_FET} owner_e;

  typedef enum logic {ST_RUN, ST_LOAD} state_e;

endpackage

// File: rtl/n1_arb_pick.sv
// Combinational priority picker: loader always wins, the core only outside LOAD,
// data over fetch unless fetch has been promoted by the starvation guard.
module n1_arb_pick
  import n1_mem_pkg::*;
(
  input  logic       ldr_req,
  input  logic       dat_req,
  input  logic       fet_req,
  input  logic       load_mode,
  input  logic       fet_promote,
  output logic [2:0] gnt_oh
);

  always_comb begin
    gnt_oh = '0;
    if (ldr_req) begin
      gnt_oh[GNT_LDR] = 1'b1;
    end else if (!load_mode) begin
      if (fet_req && fet_promote) begin
        gnt_oh[GNT_FET] = 1'b1;
      end else if (dat_req) begin
        gnt_oh[GNT_DAT] = 1'b1;
      end else if (fet_req) begin
        gnt_oh[GNT_FET] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n1_mem_arbiter.sv
// Shares one write-first synchronous RAM between loader, data and fetch ports.
// Define N1_ARB_STARVE_EN to build the fetch starvation counter and promotion.
module n1_mem_arbiter
  import n1_mem_pkg::*;
#(
  parameter int ADDR_W     = N1_ADDR_W,
  parameter int DATA_W     = N1_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  input  logic              fet_req,
  input  logic [ADDR_W-1:0] fet_addr,
  output logic              fet_gnt,
  output logic              fet_rvalid,
  input  logic              dat_req,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  output logic              dat_gnt,
  output logic              dat_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_mode
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   pending_q, pending_d;
  logic   fet_promote;
  logic   [2:0] gnt_oh;

  // Nothing is granted while reset is held, even if requests are pending.
  assign load_mode = !rst && ((state_q == ST_LOAD) || ldr_req);

  n1_arb_pick u_pick (
    .ldr_req     (ldr_req && !rst),
    .dat_req     (dat_req && !rst),
    .fet_req     (fet_req && !rst),
    .load_mode   (load_mode),
    .fet_promote (fet_promote),
    .gnt_oh      (gnt_oh)
  );

  assign ldr_gnt = gnt_oh[GNT_LDR];
  assign dat_gnt = gnt_oh[GNT_DAT];
  assign fet_gnt = gnt_oh[GNT_FET];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (ldr_req)  state_d = ST_LOAD;
      ST_LOAD: if (!ldr_req) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    owner_d   = OWN_NONE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_oh[GNT_LDR]) begin
      owner_d   = OWN_LDR;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else if (gnt_oh[GNT_DAT]) begin
      owner_d   = OWN_DAT;
      mem_we    = dat_we;
      mem_addr  = dat_addr;
      mem_wdata = dat_wdata;
    end else if (gnt_oh[GNT_FET]) begin
      owner_d   = OWN_FET;
      mem_addr  = fet_addr;
    end
    mem_en    = |gnt_oh;
    pending_d = mem_en && !mem_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      owner_q   <= OWN_NONE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
    end
  end

  // Read data lands one cycle after the grant; tag it for the recorded owner.
  assign rdata      = mem_rdata;
  assign ldr_rvalid = !rst && pending_q && (owner_q == OWN_LDR);
  assign dat_rvalid = !rst && pending_q && (owner_q == OWN_DAT);
  assign fet_rvalid = !rst && pending_q && (owner_q == OWN_FET);

`ifdef N1_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (load_mode || fet_gnt) begin
      starve_d = '0;
    end else if (fet_req && (starve_q < CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign fet_promote = (starve_q >= CNT_W'(STARVE_MAX));
`else
  // Without the guard the threshold has no meaning; fetch is never promoted.
  assign fet_promote = 1'b0 && (STARVE_MAX > 0);
`endif

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Randomized and directed bench for n1_mem_arbiter against a cycle-level reference model.
module tb_n1_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SMAX = 4;
`ifdef N1_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  localparam int W_NONE = 0;
  localparam int W_LDR  = 1;
  localparam int W_DAT  = 2;
  localparam int W_FET  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_gnt, ldr_rvalid;
  logic          fet_req = 1'b0;
  logic [AW-1:0] fet_addr = '0;
  logic          fet_gnt, fet_rvalid;
  logic          dat_req = 1'b0, dat_we = 1'b0;
  logic [AW-1:0] dat_addr = '0;
  logic [DW-1:0] dat_wdata = '0;
  logic          dat_gnt, dat_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          load_mode;

  always #5 clk = ~clk;

  n1_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_gnt(fet_gnt), .fet_rvalid(fet_rvalid),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
    .dat_gnt(dat_gnt), .dat_rvalid(dat_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .load_mode(load_mode)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 37 + 256);
  endfunction

  // Write-first synchronous RAM attached to the arbiter's port.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_rd;
  bit            ram_load = 1'b1;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        ram_rd        <= mem_wdata;
      end else begin
        ram_rd <= ram[mem_addr];
      end
    end
  end
  assign mem_rdata = ram_rd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what the arbiter should remember across cycles.
  bit            m_load = 1'b0;
  int            m_starve = 0;
  bit            m_pend = 1'b0;
  int            m_own = W_NONE;
  int            m_win = W_NONE;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] m_mem [256];

  int            e_win;
  bit            e_load, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  logic [2:0]    obs_gnt, obs_rv;
  logic [DW-1:0] obs_rdata;
  int            ldr_left = 0;

  task automatic model_eval();
    e_win = W_NONE; e_load = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (!rst) begin
      e_load = m_load || ldr_req;
      if (ldr_req) e_win = W_LDR;
      else if (!e_load) begin
        if (STARVE_ON && fet_req && m_starve >= SMAX) e_win = W_FET;
        else if (dat_req) e_win = W_DAT;
        else if (fet_req) e_win = W_FET;
      end
    end
    case (e_win)
      W_LDR: begin e_we = ldr_we; e_addr = ldr_addr; e_wdata = ldr_wdata; end
      W_DAT: begin e_we = dat_we; e_addr = dat_addr; e_wdata = dat_wdata; end
      W_FET: e_addr = fet_addr;
      default: ;
    endcase
  endtask

  task automatic model_commit();
    if (rst) begin
      m_load = 1'b0; m_starve = 0; m_pend = 1'b0; m_own = W_NONE; m_win = W_NONE;
    end else begin
      if (e_win != W_NONE && e_we) m_mem[e_addr] = e_wdata;
      if (e_win != W_NONE && !e_we) m_rd = m_mem[e_addr];
      m_pend = (e_win != W_NONE) && !e_we;
      m_own  = e_win;
      if (e_load || e_win == W_FET) m_starve = 0;
      else if (fet_req && m_starve < SMAX) m_starve++;
      m_load = ldr_req;
      m_win  = e_win;
    end
  endtask

  task automatic step();
    logic [2:0] eg, erv;
    model_eval();
    eg = 3'b000;
    if (e_win == W_LDR) eg = 3'b001;
    if (e_win == W_DAT) eg = 3'b010;
    if (e_win == W_FET) eg = 3'b100;
    erv = 3'b000;
    if (!rst && m_pend) begin
      if (m_own == W_LDR) erv = 3'b001;
      if (m_own == W_DAT) erv = 3'b010;
      if (m_own == W_FET) erv = 3'b100;
    end
    @(negedge clk);
    obs_gnt   = {fet_gnt, dat_gnt, ldr_gnt};
    obs_rv    = {fet_rvalid, dat_rvalid, ldr_rvalid};
    obs_rdata = rdata;
    check_eq("gnt", 32'(obs_gnt), 32'(eg));
    check_eq("mem_en", 32'(mem_en), 32'(e_win != W_NONE));
    check_eq("mem_we", 32'(mem_we), 32'(e_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check_eq("load_mode", 32'(load_mode), 32'(e_load));
    check_eq("rvalid", 32'(obs_rv), 32'(erv));
    if (erv != 3'b000) check_eq("rdata", 32'(obs_rdata), 32'(m_rd));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; ldr_req = 1'b0; dat_req = 1'b0; fet_req = 1'b0;
    ldr_we = 1'b0; dat_we = 1'b0;
  endtask

  // Requesters keep an ungranted request stable and may issue a fresh one after a grant.
  task automatic rand_inputs();
    rst = ($urandom_range(0, 79) == 0);
    if (!ldr_req || m_win == W_LDR) begin
      if (ldr_left > 0) begin
        ldr_left--;
        ldr_req = 1'b1; ldr_we = 1'($urandom_range(0, 1));
        ldr_addr = AW'($urandom_range(0, 31)); ldr_wdata = DW'($urandom);
      end else begin
        ldr_req = 1'b0;
        if ($urandom_range(0, 24) == 0) ldr_left = $urandom_range(1, 5);
      end
    end
    if (!dat_req || m_win == W_DAT) begin
      dat_req = ($urandom_range(0, 2) != 0); dat_we = 1'($urandom_range(0, 1));
      dat_addr = AW'($urandom_range(0, 31)); dat_wdata = DW'($urandom);
    end
    if (!fet_req || m_win == W_FET) begin
      fet_req = ($urandom_range(0, 3) != 0);
      fet_addr = AW'($urandom_range(0, 31));
    end
  endtask

  initial begin
    int nf;
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);

    // Reset with every requester asking.
    rst = 1'b1; ldr_req = 1'b1; dat_req = 1'b1; fet_req = 1'b1; ldr_we = 1'b1;
    step();
    ram_load = 1'b0;
    step();
    check_eq("rst_gnt", 32'(obs_gnt), 32'h0);
    check_eq("rst_load_mode", 32'(load_mode), 32'h0);
    idle();
    step();

    // Loader session with fetch waiting behind it.
    fet_req = 1'b1; fet_addr = 8'h00;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h05; ldr_wdata = 16'h1234;
    step();
    check_eq("ses_wr_gnt", 32'(obs_gnt), 32'h1);
    ldr_we = 1'b0;
    step();
    ldr_req = 1'b0;
    step();
    check_eq("ses_ldr_rv", 32'(obs_rv), 32'h1);
    check_eq("ses_rdata", 32'(obs_rdata), 32'h1234);
    check_eq("ses_fet_locked", 32'(obs_gnt), 32'h0);
    step();
    check_eq("ses_fet_gnt", 32'(obs_gnt), 32'h4);
    idle();

    // Preload words for the routing test, then return to RUN.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h00; ldr_wdata = 16'h1005;
    step();
    ldr_addr = 8'h10; ldr_wdata = 16'h00AA;
    step();
    idle();
    step();

    // Back-to-back reads by fetch then data.
    fet_req = 1'b1; fet_addr = 8'h00;
    step();
    fet_req = 1'b0; dat_req = 1'b1; dat_we = 1'b0; dat_addr = 8'h10;
    step();
    check_eq("rt_fet_rv", 32'(obs_rv), 32'h4);
    check_eq("rt_fet_data", 32'(obs_rdata), 32'h1005);
    dat_req = 1'b0;
    step();
    check_eq("rt_dat_rv", 32'(obs_rv), 32'h2);
    check_eq("rt_dat_data", 32'(obs_rdata), 32'h00AA);

    // Data write followed immediately by a fetch read of the same word.
    dat_req = 1'b1; dat_we = 1'b1; dat_addr = 8'h20; dat_wdata = 16'hBEEF;
    step();
    dat_req = 1'b0; fet_req = 1'b1; fet_addr = 8'h20;
    step();
    fet_req = 1'b0;
    step();
    check_eq("wr_rd_rv", 32'(obs_rv), 32'h4);
    check_eq("wr_rd_data", 32'(obs_rdata), 32'hBEEF);

    // Sustained data/fetch contention from a cleared counter.
    rst = 1'b1;
    step();
    rst = 1'b0; dat_req = 1'b1; dat_we = 1'b0; dat_addr = 8'h01; fet_req = 1'b1; fet_addr = 8'h02;
    nf = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (obs_gnt[2]) nf++;
      check_eq("ct_pos", 32'(obs_gnt), (STARVE_ON && (k % 5 == 4)) ? 32'h4 : 32'h2);
    end
    check_eq("ct_fet_cnt", 32'(nf), STARVE_ON ? 32'd3 : 32'd0);

    // Reset landing on a data read: no rvalid, counter back to zero.
    idle();
    step();
    dat_req = 1'b1; fet_req = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    check_eq("rm_gnt", 32'(obs_gnt), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) check_eq("rm_no_rv", 32'(obs_rv), 32'h0);
      check_eq("rm_pos", 32'(obs_gnt), (STARVE_ON && k == 4) ? 32'h4 : 32'h2);
    end
    idle();
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
